ctrl_pipe_chain: RTL and testbench

- Parametrised control-signal pipeline: carries a CW-bit decoded control word from decode through STAGES register stages (e.g. E, M, W).
- Each stage has a valid bit, a per-stage stall, and a per-stage flush. Stall back-pressure propagates upstream automatically, and a bubble is inserted below a held stage.
- Replaces the hand-built fixed-width control registers between decode and writeback in the pipelined core.

---
 rtl/ctrl_pipe_chain.sv | 123 ++++++++++++
 tb/tb_ctrl_pipe_chain.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Parametrised control-word pipeline with per-stage valid/stall/flush and upstream stall propagation.
// Optional saturating perf counters are built only when CTRL_PIPE_PERF_CNT_EN is defined.
module ctrl_pipe_chain #(
    parameter int CW     = 8,
    parameter int STAGES = 3,
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        ctrl_in,
    input  logic                 valid_in,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    input  logic                 flush_all,
    output logic                 ready_in,
    output logic [STAGES*CW-1:0] ctrl_out,
    output logic [STAGES-1:0]    valid_out,
    input  logic                 clr_cnt,
    output logic [CNTW-1:0]      bubble_cnt,
    output logic [CNTW-1:0]      stall_cnt
);

    logic [CW-1:0]     r_ctrl [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_bubble;
    logic [CW-1:0]     w_src_ctrl [STAGES];
    logic [STAGES-1:0] w_src_valid;

    // hold[k] is the OR of every stall at or below stage k
    always_comb begin
        w_hold = '0;
        w_hold[STAGES-1] = stall[STAGES-1];
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_hold[STAGES-1-i] = stall[STAGES-1-i] | w_hold[STAGES-i];
        end
    end

    always_comb begin
        w_bubble = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_bubble[k] = w_hold[k-1];
        end
    end

    // Stage 0 zeroes the word of a non-valid input so that valid=0 always means ctrl=0
    always_comb begin
        w_src_valid   = '0;
        w_src_valid[0] = valid_in;
        w_src_ctrl[0]  = valid_in ? ctrl_in : '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_ctrl[k]  = r_ctrl[k-1];
        end
    end

    assign ready_in = ~w_hold[0] & ~flush_all;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_ctrl[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (flush_all || flush[k]) begin
                    r_ctrl[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else if (w_hold[k]) begin
                    r_ctrl[k]  <= r_ctrl[k];
                    r_valid[k] <= r_valid[k];
                end else if (w_bubble[k]) begin
                    r_ctrl[k]  <= '0;
                    r_valid[k] <= 1'b0;
                end else begin
                    r_ctrl[k]  <= w_src_ctrl[k];
                    r_valid[k] <= w_src_valid[k];
                end
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            ctrl_out[k*CW +: CW] = r_ctrl[k];
        end
    end

    assign valid_out = r_valid;

`ifdef CTRL_PIPE_PERF_CNT_EN
    logic [CNTW-1:0] r_bubble_cnt;
    logic [CNTW-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else if (clr_cnt) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (!r_valid[STAGES-1] && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNTW'(1);
            end
            if (!ready_in && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign stall_cnt  = r_stall_cnt;
`else
    logic w_unused_clr_cnt;
    assign w_unused_clr_cnt = clr_cnt;
    assign bubble_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed self-checking bench for ctrl_pipe_chain (CW=8, STAGES=3, CNTW=4).
// Counter expectations follow CTRL_PIPE_PERF_CNT_EN when it is defined for the build.
module tb_ctrl_pipe_chain;

    localparam int CW     = 8;
    localparam int STAGES = 3;
    localparam int CNTW   = 4;
`ifdef CTRL_PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic [CW-1:0]        ctrl_in;
    logic                 valid_in;
    logic [STAGES-1:0]    stall;
    logic [STAGES-1:0]    flush;
    logic                 flush_all;
    logic                 ready_in;
    logic [STAGES*CW-1:0] ctrl_out;
    logic [STAGES-1:0]    valid_out;
    logic                 clr_cnt;
    logic [CNTW-1:0]      bubble_cnt;
    logic [CNTW-1:0]      stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_pipe_chain #(.CW(CW), .STAGES(STAGES), .CNTW(CNTW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .stall      (stall),
        .flush      (flush),
        .flush_all  (flush_all),
        .ready_in   (ready_in),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .clr_cnt    (clr_cnt),
        .bubble_cnt (bubble_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pipe(input string tag, input logic [23:0] exp_ctrl, input logic [2:0] exp_valid);
        check({tag, ".ctrl"}, {8'h0, ctrl_out}, {8'h0, exp_ctrl});
        check({tag, ".valid"}, {29'h0, valid_out}, {29'h0, exp_valid});
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] exp_bub, input logic [3:0] exp_stl);
        check({tag, ".bubble_cnt"}, {28'h0, bubble_cnt}, PERF ? {28'h0, exp_bub} : 32'h0);
        check({tag, ".stall_cnt"}, {28'h0, stall_cnt}, PERF ? {28'h0, exp_stl} : 32'h0);
    endtask

    initial begin
        reset     = 1'b0;
        ctrl_in   = '0;
        valid_in  = 1'b0;
        stall     = '0;
        flush     = '0;
        flush_all = 1'b0;
        clr_cnt   = 1'b0;

        // reset state
        tick();
        check("reset.ready_in", {31'h0, ready_in}, 32'h1);
        check_pipe("reset", 24'h000000, 3'b000);
        check_cnt("reset", 4'h0, 4'h0);
        tick();
        reset = 1'b1;

        // stream A1..A4, stage 2 is ctrl_out[23:16]
        valid_in = 1'b1;
        ctrl_in = 8'hA1; tick();
        check_pipe("stream1", 24'h0000A1, 3'b001);
        ctrl_in = 8'hA2; tick();
        ctrl_in = 8'hA3; tick();
        check_pipe("stream3", 24'hA1A2A3, 3'b111);
        ctrl_in = 8'hA4; tick();
        check_pipe("stream4", 24'hA2A3A4, 3'b111);

        // stall stage 1 for two cycles
        ctrl_in = 8'hA5; stall = 3'b010;
        #1 check("stall.ready0", {31'h0, ready_in}, 32'h0);
        tick();
        check_pipe("stall1", 24'h00A3A4, 3'b011);
        check("stall.ready1", {31'h0, ready_in}, 32'h0);
        tick();
        check_pipe("stall2", 24'h00A3A4, 3'b011);
        stall = 3'b000;
        #1 check("stall.ready_rel", {31'h0, ready_in}, 32'h1);
        tick();
        check_pipe("resume1", 24'hA3A4A5, 3'b111);
        ctrl_in = 8'hA6; tick();
        check_pipe("resume2", 24'hA4A5A6, 3'b111);

        // invalid input with non-zero word enters as zero
        ctrl_in = 8'hFF; valid_in = 1'b0; tick();
        check_pipe("invalid_in", 24'hA5A600, 3'b110);

        // flush and stall on stage 0 together
        ctrl_in = 8'h5C; valid_in = 1'b1; tick();
        check_pipe("load5C", 24'hA6005C, 3'b101);
        ctrl_in = 8'h77; stall = 3'b001; flush = 3'b001; tick();
        check_pipe("flush_stall", 24'h000000, 3'b000);
        flush = 3'b000; tick();
        check_pipe("flush_stall_hold", 24'h000000, 3'b000);
        check("flush_stall.ready", {31'h0, ready_in}, 32'h0);
        stall = 3'b000;

        // flush_all on a full pipe
        ctrl_in = 8'h11; tick();
        ctrl_in = 8'h22; tick();
        ctrl_in = 8'h33; tick();
        check_pipe("full", 24'h112233, 3'b111);
        ctrl_in = 8'h44; flush_all = 1'b1;
        #1 check("flush_all.ready", {31'h0, ready_in}, 32'h0);
        tick();
        check_pipe("flush_all", 24'h000000, 3'b000);
        flush_all = 1'b0; tick();
        check_pipe("after_flush_all", 24'h000044, 3'b001);

        // single-stage flush leaves neighbours alone
        ctrl_in = 8'h55; tick();
        ctrl_in = 8'h66; flush = 3'b010; tick();
        check_pipe("flush1", 24'h440066, 3'b101);
        flush = 3'b000;

        // async reset between edges
        ctrl_in = 8'h77; tick();
        check_pipe("pre_areset", 24'h006677, 3'b011);
        #2 reset = 1'b0;
        #1 check_pipe("areset", 24'h000000, 3'b000);
        check_cnt("areset", 4'h0, 4'h0);
        #1 reset = 1'b1;
        ctrl_in = 8'h88; tick();
        check_pipe("post_areset", 24'h000088, 3'b001);
        check_cnt("post_areset", 4'h1, 4'h0);

        // counter saturation and clear
        stall = 3'b100;
        repeat (3) tick();
        check_cnt("cnt3", 4'h4, 4'h3);
        check_pipe("stall2_hold", 24'h000088, 3'b001);
        repeat (17) tick();
        check_cnt("cnt_sat", 4'hF, 4'hF);
        clr_cnt = 1'b1; tick();
        check_cnt("cnt_clr", 4'h0, 4'h0);
        clr_cnt = 1'b0; stall = 3'b000; tick();
        check_cnt("cnt_restart", 4'h1, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
